// File: rtl/mac_acc_reduce.sv
// rtl/mac_acc_reduce.sv - per-lane burst accumulator with optional horizontal reduction
//
// Consumes the 4-lane 32-bit result stream of mac4x16_top, accumulates each lane over a
// burst into ACC_W-bit accumulators and emits one registered result per burst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream beat handshake; in_last marks the final beat of a burst
//   y_vec               {y3,y2,y1,y0}, 32 bits per lane
//   op_signed           sign- (1) or zero- (0) extend lanes; sampled on the first beat
//   reduce_en           sum all lanes into lane 0; sampled on the last beat
//   out_valid/out_ready result handshake
//   acc_vec             {acc3,acc2,acc1,acc0}
//   beat_cnt            beats in the emitted burst (saturating)
//   ovf                 sticky per-lane overflow for the emitted burst
module mac_acc_reduce #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [127:0]       y_vec,
    input  logic               op_signed,
    input  logic               reduce_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] acc_vec,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [3:0]         ovf
);

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t                  r_state;
    logic [3:0][ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_flags;
    logic                    r_signed;
    logic                    r_out_valid;
    logic [4*ACC_W-1:0]      r_acc_vec;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic [3:0]              r_ovf;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_sgn;
    logic [3:0][ACC_W-1:0]   w_ext;
    logic [3:0][ACC_W:0]     w_lane_res;
    logic [3:0][ACC_W-1:0]   w_lane;
    logic [3:0]              w_lane_ovf;
    logic [ACC_W:0]          w_r01;
    logic [ACC_W:0]          w_r012;
    logic [ACC_W:0]          w_rsum;
    logic [CNT_W-1:0]        w_cnt_next;

    // Returns {overflow, sum}; overflow follows the signed or unsigned rule.
    function automatic logic [ACC_W:0] add_chk(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input logic             sgn);
        logic [ACC_W:0] s;
        logic           v;
        s = {1'b0, a} + {1'b0, b};
        if (sgn) v = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        else     v = s[ACC_W];
        return {v, s[ACC_W-1:0]};
    endfunction

    assign in_ready  = !rst && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign acc_vec   = r_acc_vec;
    assign beat_cnt  = r_beat_cnt;
    assign ovf       = r_ovf;

    always_comb begin
        w_first = (r_state == S_IDLE);
        // Signedness is frozen for the burst once the first beat has been taken.
        w_sgn   = w_first ? op_signed : r_signed;
        w_ext      = '0;
        w_lane_res = '0;
        w_lane     = '0;
        w_lane_ovf = '0;
        for (int i = 0; i < 4; i++) begin
            w_ext[i] = w_sgn ? {{(ACC_W-32){y_vec[32*i+31]}}, y_vec[32*i +: 32]}
                             : {{(ACC_W-32){1'b0}}, y_vec[32*i +: 32]};
            // A fresh burst adds to zero, which can never overflow.
            w_lane_res[i] = add_chk(w_first ? '0 : r_acc[i], w_ext[i], w_sgn);
            w_lane[i]     = w_lane_res[i][ACC_W-1:0];
            w_lane_ovf[i] = (!w_first && r_flags[i]) || w_lane_res[i][ACC_W];
        end
        w_r01  = add_chk(w_lane[0], w_lane[1], w_sgn);
        w_r012 = add_chk(w_r01[ACC_W-1:0], w_lane[2], w_sgn);
        w_rsum = add_chk(w_r012[ACC_W-1:0], w_lane[3], w_sgn);
        if (w_first)     w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (&r_cnt) w_cnt_next = r_cnt;
        else             w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_flags     <= '0;
            r_signed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_vec   <= '0;
            r_beat_cnt  <= '0;
            r_ovf       <= '0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_accept) begin
                if (in_last) begin
                    // in_ready guarantees the output register is free or draining now.
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b1;
                    r_beat_cnt  <= w_cnt_next;
                    if (reduce_en) begin
                        r_acc_vec <= {{(3*ACC_W){1'b0}}, w_rsum[ACC_W-1:0]};
                        r_ovf     <= {3'b000, (|w_lane_ovf) | w_r01[ACC_W]
                                              | w_r012[ACC_W] | w_rsum[ACC_W]};
                    end else begin
                        r_acc_vec <= w_lane;
                        r_ovf     <= w_lane_ovf;
                    end
                end else begin
                    r_state <= S_ACC;
                    r_acc   <= w_lane;
                    r_cnt   <= w_cnt_next;
                    r_flags <= w_lane_ovf;
                    if (w_first) r_signed <= op_signed;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_reduce.sv
// tb/tb_mac_acc_reduce.sv - self-checking bench for mac_acc_reduce
module tb_mac_acc_reduce;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [127:0] y_vec;
    logic         op_signed;
    logic         reduce_en;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] acc_vec;
    logic [15:0]  beat_cnt;
    logic [3:0]   ovf;

    int ntests = 0;
    int nfail  = 0;

    typedef struct packed {
        logic [3:0][31:0] y;
        logic             sgn;
        logic             red;
        logic [15:0]      n;
        logic [3:0][39:0] ea;
        logic [15:0]      ecnt;
        logic [3:0]       eovf;
    } vec_t;

    typedef struct packed {
        logic [159:0] acc;
        logic [15:0]  cnt;
        logic [3:0]   ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    vec_t tbl[8];

    mac_acc_reduce #(.ACC_W(40), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .y_vec     (y_vec),
        .op_signed (op_signed),
        .reduce_en (reduce_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_vec   (acc_vec),
        .beat_cnt  (beat_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] y0, y1, y2, y3, input logic sgn, red,
                                input logic [15:0] n, input logic [39:0] a0, a1, a2, a3,
                                input logic [15:0] cnt, input logic [3:0] ov);
        vec_t v;
        v.y    = {y3, y2, y1, y0};
        v.sgn  = sgn;
        v.red  = red;
        v.n    = n;
        v.ea   = {a3, a2, a1, a0};
        v.ecnt = cnt;
        v.eovf = ov;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [39:0] a0, a1, a2, a3,
                                    input logic [15:0] cnt, input logic [3:0] ov);
        exp_t e;
        e.acc = {a3, a2, a1, a0};
        e.cnt = cnt;
        e.ovf = ov;
        return e;
    endfunction

    // Scoreboard: every handshaken result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_output: got acc %h cnt %0d, expected no result", acc_vec, beat_cnt);
            end else begin
                m_e = exp_q.pop_front();
                chk("acc_vec", acc_vec, m_e.acc);
                chk("beat_cnt", {144'b0, beat_cnt}, {144'b0, m_e.cnt});
                chk("ovf", {156'b0, ovf}, {156'b0, m_e.ovf});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [127:0] y, input logic last, sgn, red);
        bit ok;
        in_valid  = 1'b1;
        y_vec     = y;
        in_last   = last;
        op_signed = sgn;
        reduce_en = red;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            ntests++;
            nfail++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        y_vec    = '0;
    endtask

    task automatic send_burst(input vec_t v);
        for (int b = 0; b < int'(v.n); b++) begin
            if (b == int'(v.n) - 1) exp_q.push_back('{acc: v.ea, cnt: v.ecnt, ovf: v.eovf});
            send_beat(v.y, (b == int'(v.n) - 1), v.sgn, v.red);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_pending", 160'(exp_q.size()), 160'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(32'd5, 32'd12, 32'd21, 32'd32, 1'b0, 1'b0, 16'd1,
                    40'd5, 40'd12, 40'd21, 40'd32, 16'd1, 4'h0);
        tbl[1] = mk(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 16'd3,
                    40'hFFFFFFFFFD, 40'd0, 40'd0, 40'd0, 16'd3, 4'h0);
        tbl[2] = mk(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd3,
                    40'h02FFFFFFFD, 40'd0, 40'd0, 40'd0, 16'd3, 4'h0);
        tbl[3] = mk(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 16'd1,
                    40'd10, 40'd0, 40'd0, 40'd0, 16'd1, 4'h0);
        tbl[4] = mk(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd257,
                    40'h00FFFFFEFF, 40'd0, 40'd0, 40'd0, 16'd257, 4'h1);
        tbl[5] = mk(32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0, 16'd2,
                    40'hFFFFFFFFFC, 40'hFF00000000, 40'h00FFFFFFFE, 40'd2, 16'd2, 4'h0);
        tbl[6] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 16'd2,
                    40'hFFFFFFFFF8, 40'd0, 40'd0, 40'd0, 16'd2, 4'h0);
        // Lanes stay in range (2^38-128) but the signed lane sum exceeds 2^39-1.
        tbl[7] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 16'd128,
                    40'hFFFFFFFE00, 40'd0, 40'd0, 40'd0, 16'd128, 4'h1);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        y_vec     = '0;
        op_signed = 1'b0;
        reduce_en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {159'b0, out_valid}, 160'd0);
        chk("rst_acc_vec", acc_vec, 160'd0);
        chk("rst_beat_cnt", {144'b0, beat_cnt}, 160'd0);
        chk("rst_ovf", {156'b0, ovf}, 160'd0);
        chk("rst_in_ready", {159'b0, in_ready}, 160'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {159'b0, in_ready}, 160'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            send_burst(tbl[i]);
            drain();
        end

        // op_signed is taken from the first beat, reduce_en from the last.
        exp_q.push_back(mk_exp(40'hFFFFFFFFFE, 40'd2, 40'd0, 40'd0, 16'd2, 4'h0));
        send_beat({32'd0, 32'd0, 32'd1, 32'hFFFFFFFF}, 1'b0, 1'b1, 1'b1);
        send_beat({32'd0, 32'd0, 32'd1, 32'hFFFFFFFF}, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-pressure: result held, a competing last beat must not get in.
        out_ready = 1'b0;
        exp_q.push_back(mk_exp(40'd5, 40'd6, 40'd7, 40'd8, 16'd1, 4'h0));
        send_beat({32'd8, 32'd7, 32'd6, 32'd5}, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_last  = 1'b1;
        y_vec    = {4{32'h0BAD0BAD}};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", {159'b0, out_valid}, 160'd1);
            chk("hold_in_ready", {159'b0, in_ready}, 160'd0);
            chk("hold_acc_vec", acc_vec, {40'd8, 40'd7, 40'd6, 40'd5});
            chk("hold_beat_cnt", {144'b0, beat_cnt}, 160'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(mk_exp(40'd9, 40'd0, 40'd0, 40'd0, 16'd1, 4'h0));
        send_beat({96'b0, 32'd9}, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("handoff_out_valid", {159'b0, out_valid}, 160'd1);
        drain();

        // Reset mid-burst discards the partial sums.
        send_beat({96'b0, 32'd100}, 1'b0, 1'b0, 1'b0);
        send_beat({96'b0, 32'd100}, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {159'b0, in_ready}, 160'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_out_valid", {159'b0, out_valid}, 160'd0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(40'd7, 40'd0, 40'd0, 40'd0, 16'd1, 4'h0));
        send_beat({96'b0, 32'd7}, 1'b1, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
